// File: rtl/bytecode_fetch.sv
// Instruction fetch stage: reads opcode and 0-2 big-endian argument bytes from
// single-cycle program memory and hands a complete instruction to execute.
module bytecode_fetch #(
    parameter int PC_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PC_WIDTH-1:0] mem_addr,
    output logic                mem_rd,
    input  logic [7:0]          mem_data,
    output logic [7:0]          opcode,
    input  logic [1:0]          argc,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [15:0]         instr_arg,
    output logic [PC_WIDTH-1:0] instr_pc,
    input  logic                branch_taken,
    input  logic [15:0]         branch_offset,
    input  logic                halt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP,
        S_OPLAT,
        S_DECODE,
        S_ARG1,
        S_ARG2,
        S_ISSUE
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_instr_pc;
    logic [7:0]          r_opcode;
    logic [15:0]         r_instr_arg;

    logic                w_rd;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_off_ext;
    logic [PC_WIDTH-1:0] w_target;

    // Branch offset is signed and relative to the opcode address.
    assign w_off_ext = PC_WIDTH'($signed(branch_offset));
    assign w_pc_inc  = r_pc + PC_ONE;
    assign w_target  = r_instr_pc + w_off_ext;

    // Strobes depend on argc in DECODE/ARG1, so they cannot be registered ahead.
    always_comb begin
        w_rd = 1'b0;
        case (r_state)
            S_OP:     w_rd = 1'b1;
            S_DECODE: w_rd = (argc != 2'd0);
            S_ARG1:   w_rd = argc[1];
            default:  w_rd = 1'b0;
        endcase
    end

    assign mem_rd      = w_rd;
    assign mem_addr    = w_rd ? r_pc : '0;
    assign instr_valid = (r_state == S_ISSUE);
    assign opcode      = r_opcode;
    assign instr_arg   = r_instr_arg;
    assign instr_pc    = r_instr_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_instr_pc  <= '0;
            r_opcode    <= '0;
            r_instr_arg <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!halt) r_state <= S_OP;
                end
                S_OP: begin
                    r_instr_pc <= r_pc;
                    r_pc       <= w_pc_inc;
                    r_state    <= S_OPLAT;
                end
                S_OPLAT: begin
                    r_opcode    <= mem_data;
                    r_instr_arg <= '0;
                    r_state     <= S_DECODE;
                end
                S_DECODE: begin
                    if (argc == 2'd0) begin
                        r_state <= S_ISSUE;
                    end else begin
                        r_pc    <= w_pc_inc;
                        r_state <= S_ARG1;
                    end
                end
                S_ARG1: begin
                    r_instr_arg <= {8'h00, mem_data};
                    if (argc[1]) begin
                        r_pc    <= w_pc_inc;
                        r_state <= S_ARG2;
                    end else begin
                        r_state <= S_ISSUE;
                    end
                end
                S_ARG2: begin
                    r_instr_arg <= {r_instr_arg[7:0], mem_data};
                    r_state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (instr_ready) begin
                        if (branch_taken) r_pc <= w_target;
                        r_state <= halt ? S_IDLE : S_OP;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bytecode_fetch.sv
// Bench for bytecode_fetch: program-memory and decoder models, an instruction-level
// reference checked every cycle, and directed scenarios with literal expectations.
module tb_bytecode_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data = 8'h00;
    logic [7:0]  opcode;
    logic [1:0]  argc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr_arg;
    logic [15:0] instr_pc;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_offset = 16'h0000;
    logic        halt = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [7:0] mem [0:65535];

    bytecode_fetch #(.PC_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
        .opcode(opcode), .argc(argc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_arg(instr_arg), .instr_pc(instr_pc),
        .branch_taken(branch_taken), .branch_offset(branch_offset), .halt(halt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

    // Decoder: NOP=00, BIPUSH=10, SIPUSH=11, GOTO=A7, FF reports 3 args
    always_comb begin
        argc = 2'd0;
        case (opcode)
            8'h10:        argc = 2'd1;
            8'h11, 8'hA7: argc = 2'd2;
            8'hFF:        argc = 2'd3;
            default:      argc = 2'd0;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int nargs(input logic [7:0] op);
        case (op)
            8'h10:               return 1;
            8'h11, 8'hA7, 8'hFF: return 2;
            default:             return 0;
        endcase
    endfunction

    // Instruction-level reference: m_pc is the opcode address of the next instruction.
    initial begin
        logic [15:0] m_pc;
        logic [15:0] a1;
        logic [15:0] a2;
        logic [15:0] exp_arg;
        int k;
        int t_op;
        int seen;
        int n;
        m_pc = 0; k = 0; t_op = 0; seen = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_pc = 0; k = 0; seen = 0;
            end else begin
                if (mem_rd) begin
                    chk("rd_addr", {16'h0, mem_addr}, {16'h0, m_pc + 16'(k)});
                    chk("rd_during_issue", {31'h0, instr_valid}, 32'h0);
                    if (k == 0) t_op = cyc;
                    k++;
                end else begin
                    chk("addr_when_idle", {16'h0, mem_addr}, 32'h0);
                end
                if (instr_valid) begin
                    n  = nargs(mem[m_pc]);
                    a1 = m_pc + 16'd1;
                    a2 = m_pc + 16'd2;
                    exp_arg = (n == 0) ? 16'h0000 :
                              (n == 1) ? {8'h00, mem[a1]} : {mem[a1], mem[a2]};
                    chk("opcode", {24'h0, opcode}, {24'h0, mem[m_pc]});
                    chk("instr_arg", {16'h0, instr_arg}, {16'h0, exp_arg});
                    chk("instr_pc", {16'h0, instr_pc}, {16'h0, m_pc});
                    if (seen == 0) begin
                        chk("latency", cyc - t_op, 3 + n);
                        seen = 1;
                    end
                    if (instr_ready) begin
                        m_pc = branch_taken ? (m_pc + branch_offset) : (m_pc + 16'(1 + n));
                        k = 0;
                        seen = 0;
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        instr_ready = 1'b0; branch_taken = 1'b0; branch_offset = 16'h0; halt = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(output int t);
        int i;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!instr_valid && i < 100);
        if (!instr_valid) chk("valid_timeout", 32'h0, 32'h1);
        t = cyc;
    endtask

    task automatic wait_rd(output logic [15:0] addr, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!mem_rd && waited < 100);
        if (!mem_rd) chk("rd_timeout", 32'h0, 32'h1);
        addr = mem_addr;
    endtask

    task automatic handshake(input logic br, input logic [15:0] off, input logic hl);
        @(posedge clk); #1;
        instr_ready = 1'b1; branch_taken = br; branch_offset = off; halt = hl;
        @(posedge clk); #1;
        instr_ready = 1'b0; branch_taken = 1'b0; branch_offset = 16'h0;
    endtask

    initial begin
        int t1, t2, w;
        logic [15:0] a;
        logic [7:0]  s_op;
        logic [15:0] s_arg, s_pc;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        // NOP stream with instr_ready tied high
        apply_reset();
        instr_ready = 1'b1;
        @(negedge clk);
        chk("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
        chk("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_opcode", {24'h0, opcode}, 32'h0);
        chk("rst_arg", {16'h0, instr_arg}, 32'h0);
        chk("rst_pc", {16'h0, instr_pc}, 32'h0);
        release_reset();
        instr_ready = 1'b1;
        @(negedge clk);
        chk("first_cycle_idle", {31'h0, mem_rd}, 32'h0);
        @(negedge clk);
        chk("first_op_rd", {31'h0, mem_rd}, 32'h1);
        chk("first_op_addr", {16'h0, mem_addr}, 32'h0);
        wait_valid(t1);
        chk("nop1_opcode", {24'h0, opcode}, 32'h00);
        chk("nop1_arg", {16'h0, instr_arg}, 32'h0);
        chk("nop1_pc", {16'h0, instr_pc}, 32'h0);
        wait_valid(t2);
        chk("nop2_pc", {16'h0, instr_pc}, 32'h1);
        chk("nop_throughput", t2 - t1, 4);

        // BIPUSH 7F
        apply_reset();
        mem[0] = 8'h10; mem[1] = 8'h7F;
        release_reset();
        instr_ready = 1'b1;
        wait_valid(t1);
        chk("bipush_arg", {16'h0, instr_arg}, 32'h007F);
        chk("bipush_pc", {16'h0, instr_pc}, 32'h0);
        wait_rd(a, w);
        chk("bipush_next_addr", {16'h0, a}, 32'h2);
        chk("bipush_next_gap", w, 1);

        // SIPUSH 1234 followed by an argc=3 opcode treated as two args
        apply_reset();
        mem[0] = 8'h11; mem[1] = 8'h12; mem[2] = 8'h34;
        mem[3] = 8'hFF; mem[4] = 8'hAB; mem[5] = 8'hCD;
        release_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_rd(a, w);
            chk("sipush_rd_addr", {16'h0, a}, i);
        end
        wait_valid(t1);
        chk("sipush_arg", {16'h0, instr_arg}, 32'h1234);
        wait_rd(a, w);
        chk("sipush_next_addr", {16'h0, a}, 32'h3);
        wait_valid(t2);
        chk("argc3_arg", {16'h0, instr_arg}, 32'hABCD);
        chk("argc3_pc", {16'h0, instr_pc}, 32'h3);
        chk("sipush_throughput", t2 - t1, 6);

        // Backward GOTO at address 5
        apply_reset();
        mem[5] = 8'hA7; mem[6] = 8'hFF; mem[7] = 8'hFB;
        release_reset();
        for (int i = 0; i < 5; i++) begin
            wait_valid(t1);
            handshake(1'b0, 16'h0, 1'b0);
        end
        wait_valid(t1);
        chk("goto_opcode", {24'h0, opcode}, 32'hA7);
        chk("goto_pc", {16'h0, instr_pc}, 32'h5);
        chk("goto_arg", {16'h0, instr_arg}, 32'hFFFB);
        handshake(1'b1, 16'hFFFB, 1'b0);
        wait_rd(a, w);
        chk("goto_target", {16'h0, a}, 32'h0);
        chk("goto_target_gap", w, 1);

        // Backpressure, with branch/halt toggled while not handshaking
        apply_reset();
        mem[0] = 8'h10; mem[1] = 8'h55;
        release_reset();
        wait_valid(t1);
        s_op = opcode; s_arg = instr_arg; s_pc = instr_pc;
        @(posedge clk); #1;
        branch_taken = 1'b1; branch_offset = 16'h1234; halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'h0, instr_valid}, 32'h1);
            chk("bp_mem_rd", {31'h0, mem_rd}, 32'h0);
            chk("bp_opcode", {24'h0, opcode}, {24'h0, s_op});
            chk("bp_arg", {16'h0, instr_arg}, {16'h0, s_arg});
            chk("bp_pc", {16'h0, instr_pc}, {16'h0, s_pc});
        end
        handshake(1'b0, 16'h0, 1'b0);
        wait_rd(a, w);
        chk("bp_next_addr", {16'h0, a}, 32'h2);
        chk("bp_next_gap", w, 1);

        // Halt at handshake, then branch and halt together
        apply_reset();
        release_reset();
        wait_valid(t1);
        handshake(1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("halt_mem_rd", {31'h0, mem_rd}, 32'h0);
            chk("halt_valid", {31'h0, instr_valid}, 32'h0);
        end
        @(posedge clk); #1;
        halt = 1'b0;
        wait_rd(a, w);
        chk("halt_resume_addr", {16'h0, a}, 32'h1);
        wait_valid(t1);
        handshake(1'b1, 16'h0010, 1'b1);
        @(negedge clk);
        chk("brhalt_mem_rd", {31'h0, mem_rd}, 32'h0);
        @(posedge clk); #1;
        halt = 1'b0;
        wait_rd(a, w);
        chk("brhalt_resume_addr", {16'h0, a}, 32'h11);

        // Reset pulsed while collecting the first argument byte
        apply_reset();
        mem[0] = 8'h11; mem[1] = 8'h12; mem[2] = 8'h34;
        release_reset();
        wait_rd(a, w);
        wait_rd(a, w);
        chk("mid_decode_addr", {16'h0, a}, 32'h1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_rd", {31'h0, mem_rd}, 32'h0);
        chk("mid_rst_addr", {16'h0, mem_addr}, 32'h0);
        chk("mid_rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("mid_rst_opcode", {24'h0, opcode}, 32'h0);
        chk("mid_rst_arg", {16'h0, instr_arg}, 32'h0);
        chk("mid_rst_pc", {16'h0, instr_pc}, 32'h0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_rd(a, w);
        chk("mid_rst_restart_addr", {16'h0, a}, 32'h0);
        instr_ready = 1'b1;
        wait_valid(t1);
        chk("mid_rst_redo_arg", {16'h0, instr_arg}, 32'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
